cordic_vector_engine: RTL and testbench

- Iterative CORDIC vectoring core, placed directly downstream of the quadrant-correction stage.
- Takes the pre-rotated vector (x, y), whose x is non-negative, plus that stage's angle offset.
- Drives y to zero by successive micro-rotations, then returns the accumulated phase and the gain-scaled magnitude.
- One micro-rotation per clock, with a valid/ready handshake on both sides.

---
 rtl/cordic_vector_engine_pkg.sv | 19 +
 rtl/cordic_vector_engine_atan_rom.sv | 46 ++++
 rtl/cordic_vector_engine.sv | 111 +++++++++++
 tb/tb_cordic_vector_engine.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cordic_vector_engine_pkg.sv
// Shared CORDIC constants: angle units, engine state encoding and the CORDIC gain.
// Angles are binary angle units where 2^32 corresponds to one full turn.
package cordic_vector_engine_pkg;

   localparam int ANGLE_W = 32;

   localparam logic [ANGLE_W-1:0] ANG_90 = 32'h4000_0000;
   localparam logic [ANGLE_W-1:0] ANG_45 = 32'h2000_0000;

   // Magnitude growth of the micro-rotation chain; the engine leaves it in mag_out.
   localparam real CORDIC_GAIN = 1.6467602581210656;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cordic_vector_engine_atan_rom.sv
// Combinational arctangent table: atan(2^-idx) in binary angle units, entries 0..30.
// Zero latency; no flow control.
module cordic_atan_rom (
   input  logic [4:0]  idx,
   output logic [31:0] atan
);

   always_comb begin
      atan = 32'h0000_0000;
      case (idx)
         5'd0:  atan = 32'h2000_0000;
         5'd1:  atan = 32'h12E4_051E;
         5'd2:  atan = 32'h09FB_385B;
         5'd3:  atan = 32'h0511_11D4;
         5'd4:  atan = 32'h028B_0D43;
         5'd5:  atan = 32'h0145_D7E1;
         5'd6:  atan = 32'h00A2_F61E;
         5'd7:  atan = 32'h0051_7C55;
         5'd8:  atan = 32'h0028_BE53;
         5'd9:  atan = 32'h0014_5F2F;
         5'd10: atan = 32'h000A_2F98;
         5'd11: atan = 32'h0005_17CC;
         5'd12: atan = 32'h0002_8BE6;
         5'd13: atan = 32'h0001_45F3;
         5'd14: atan = 32'h0000_A2FA;
         5'd15: atan = 32'h0000_517D;
         5'd16: atan = 32'h0000_28BE;
         5'd17: atan = 32'h0000_145F;
         5'd18: atan = 32'h0000_0A30;
         5'd19: atan = 32'h0000_0518;
         5'd20: atan = 32'h0000_028C;
         5'd21: atan = 32'h0000_0146;
         5'd22: atan = 32'h0000_00A3;
         5'd23: atan = 32'h0000_0051;
         5'd24: atan = 32'h0000_0029;
         5'd25: atan = 32'h0000_0014;
         5'd26: atan = 32'h0000_000A;
         5'd27: atan = 32'h0000_0005;
         5'd28: atan = 32'h0000_0003;
         5'd29: atan = 32'h0000_0001;
         5'd30: atan = 32'h0000_0001;
         default: atan = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/cordic_vector_engine.sv
// Iterative CORDIC vectoring engine: drives y to zero, returns phase and gain-scaled magnitude.
// Result valid ITER+1 cycles after input handshake; holds output until out_ready, re-accepts one cycle later.
module cordic_vector_engine
   import cordic_vector_engine_pkg::*;
#(
   parameter int ITER  = 24,
   parameter int GUARD = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ANGLE_W-1:0]  x_in,
   input  logic [ANGLE_W-1:0]  y_in,
   input  logic [ANGLE_W-1:0]  angle_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ANGLE_W-1:0]  mag_out,
   output logic [ANGLE_W-1:0]  angle_out
);

   localparam int         W    = ANGLE_W + GUARD;
   localparam logic [4:0] LAST = 5'(ITER - 1);

   state_t               state;
   logic [4:0]           cnt;
   logic signed [W-1:0]  x_q, y_q;
   logic signed [W-1:0]  x_sh, y_sh, x_nxt, y_nxt;
   logic [ANGLE_W-1:0]   z_q, z_nxt, atan_val;
   logic [ANGLE_W-1:0]   mag_sat;

   cordic_atan_rom u_atan_rom (
      .idx  (cnt),
      .atan (atan_val)
   );

   // Rotate toward y = 0; both updates use the pre-iteration X and Y.
   always_comb begin
      x_sh = x_q >>> cnt;
      y_sh = y_q >>> cnt;
      if (!y_q[W-1]) begin
         x_nxt = x_q + y_sh;
         y_nxt = y_q - x_sh;
         z_nxt = z_q + atan_val;
      end else begin
         x_nxt = x_q - y_sh;
         y_nxt = y_q + x_sh;
         z_nxt = z_q - atan_val;
      end
   end

   // Guard bits that disagree with bit 31 mean the magnitude left the 32-bit signed range.
   always_comb begin
      if (x_nxt[W-1:ANGLE_W-1] == '0 || x_nxt[W-1:ANGLE_W-1] == '1)
         mag_sat = x_nxt[ANGLE_W-1:0];
      else if (x_nxt[W-1])
         mag_sat = 32'h8000_0000;
      else
         mag_sat = 32'h7FFF_FFFF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         mag_out   <= '0;
         angle_out <= '0;
         cnt       <= '0;
         x_q       <= '0;
         y_q       <= '0;
         z_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_q      <= W'($signed(x_in));
                  y_q      <= W'($signed(y_in));
                  z_q      <= angle_in;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               x_q <= x_nxt;
               y_q <= y_nxt;
               z_q <= z_nxt;
               if (cnt == LAST) begin
                  mag_out   <= mag_sat;
                  angle_out <= z_nxt;
                  out_valid <= 1'b1;
                  cnt       <= '0;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_vector_engine.sv
// Directed bench for cordic_vector_engine: known vectors with hand-derived phase/magnitude,
// handshake timing, backpressure, mid-run reset and back-to-back throughput.
module tb_cordic_vector_engine;
   import cordic_vector_engine_pkg::*;

   localparam int ITER = 24;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] x_in = '0;
   logic [31:0] y_in = '0;
   logic [31:0] angle_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] mag_out;
   logic [31:0] angle_out;

   int n_checks = 0;
   int n_fail   = 0;

   // K * 2^28 and sqrt(2) * K * 2^28
   localparam logic [31:0] MAG_UNIT = 32'h1A59_2149;
   int mag_diag;

   cordic_vector_engine #(.ITER(ITER), .GUARD(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .y_in      (y_in),
      .angle_in  (angle_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mag_out   (mag_out),
      .angle_out (angle_out)
   );

   always #5 clk = ~clk;

   // Presents one vector for exactly one clock edge; caller ensures in_ready is high.
   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] a);
      x_in = x;
      y_in = y;
      angle_in = a;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Edges until out_valid is seen high, or -1 when the budget runs out.
   task automatic wait_out(output int cyc);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!out_valid && n < 200);
      cyc = out_valid ? n : -1;
   endtask

   task automatic take_output();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (mag_out !== 32'h0) begin n_fail++; $display("FAIL reset_mag got %h want 0", mag_out); end
      n_checks++; if (angle_out !== 32'h0) begin n_fail++; $display("FAIL reset_angle got %h want 0", angle_out); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Vector on the +x axis; inputs are scribbled during RUN and must be ignored.
   task automatic test_axis_and_latency();
      int cyc, d;
      send(32'h1000_0000, 32'h0, 32'h0);
      x_in = 32'h7FFF_FFFF; y_in = 32'h1234_5678; angle_in = 32'hDEAD_BEEF;
      wait_out(cyc);
      n_checks++; if (cyc != ITER) begin n_fail++; $display("FAIL axis_latency got %0d edges want %0d", cyc, ITER); end
      d = $signed(angle_out - 32'h0);
      n_checks++; if (d > 256 || d < -256) begin n_fail++; $display("FAIL axis_angle got %h want 0 +-0x100", angle_out); end
      d = int'($signed(mag_out)) - int'(MAG_UNIT);
      n_checks++; if (d > 64 || d < -64) begin n_fail++; $display("FAIL axis_mag got %h want %h +-64", mag_out, MAG_UNIT); end
      take_output();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL axis_release_valid got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL axis_release_ready got %b want 1", in_ready); end
   endtask

   task automatic test_diagonal();
      int cyc, d;
      send(32'h1000_0000, 32'h1000_0000, 32'h0);
      wait_out(cyc);
      n_checks++; if (cyc != ITER) begin n_fail++; $display("FAIL diag_latency got %0d want %0d", cyc, ITER); end
      d = $signed(angle_out - ANG_45);
      n_checks++; if (d > 256 || d < -256) begin n_fail++; $display("FAIL diag_angle got %h want %h +-0x100", angle_out, ANG_45); end
      d = int'($signed(mag_out)) - mag_diag;
      n_checks++; if (d > 64 || d < -64) begin n_fail++; $display("FAIL diag_mag got %0d want %0d +-64", $signed(mag_out), mag_diag); end
      take_output();
   endtask

   // Below-axis vector with a 90 degree offset from the quadrant stage: 90 - 45 = 45 degrees.
   task automatic test_quadrant_offset();
      int cyc, d;
      send(32'h1000_0000, 32'hF000_0000, ANG_90);
      wait_out(cyc);
      n_checks++; if (cyc != ITER) begin n_fail++; $display("FAIL quad_latency got %0d want %0d", cyc, ITER); end
      d = $signed(angle_out - (ANG_90 - ANG_45));
      n_checks++; if (d > 256 || d < -256) begin n_fail++; $display("FAIL quad_angle got %h want 20000000 +-0x100", angle_out); end
      d = int'($signed(mag_out)) - mag_diag;
      n_checks++; if (d > 64 || d < -64) begin n_fail++; $display("FAIL quad_mag got %0d want %0d +-64", $signed(mag_out), mag_diag); end
      take_output();
   endtask

   task automatic test_saturation();
      int cyc, d;
      send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0);
      wait_out(cyc);
      n_checks++; if (cyc != ITER) begin n_fail++; $display("FAIL sat_latency got %0d want %0d", cyc, ITER); end
      n_checks++; if (mag_out !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_mag got %h want 7fffffff", mag_out); end
      d = $signed(angle_out - ANG_45);
      n_checks++; if (d > 256 || d < -256) begin n_fail++; $display("FAIL sat_angle got %h want %h +-0x100", angle_out, ANG_45); end
      take_output();
   endtask

   task automatic test_backpressure();
      int cyc;
      logic [31:0] m, a;
      send(32'h1000_0000, 32'h1000_0000, 32'h0);
      wait_out(cyc);
      n_checks++; if (cyc != ITER) begin n_fail++; $display("FAIL bp_latency got %0d want %0d", cyc, ITER); end
      m = mag_out;
      a = angle_out;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b1 || mag_out !== m || angle_out !== a || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold cycle %0d got v=%b r=%b mag=%h ang=%h want v=1 r=0 mag=%h ang=%h",
                     k, out_valid, in_ready, mag_out, angle_out, m, a);
         end
      end
      take_output();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
   endtask

   task automatic test_reset_mid_run();
      int cyc, d;
      bit seen;
      send(32'h1000_0000, 32'hF000_0000, 32'h0);
      repeat (5) @(posedge clk);   // iterations 0..4 done, 5 in progress
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
      n_checks++; if (mag_out !== 32'h0 || angle_out !== 32'h0) begin n_fail++; $display("FAIL midrst_outputs got mag=%h ang=%h want 0 0", mag_out, angle_out); end
      seen = 1'b0;
      for (int k = 0; k < ITER + 5; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      n_checks++; if (seen) begin n_fail++; $display("FAIL midrst_no_partial got out_valid=1 want 0"); end
      send(32'h1000_0000, 32'h1000_0000, 32'h0);
      wait_out(cyc);
      n_checks++; if (cyc != ITER) begin n_fail++; $display("FAIL midrst_after_latency got %0d want %0d", cyc, ITER); end
      d = $signed(angle_out - ANG_45);
      n_checks++; if (d > 256 || d < -256) begin n_fail++; $display("FAIL midrst_after_angle got %h want %h +-0x100", angle_out, ANG_45); end
      d = int'($signed(mag_out)) - mag_diag;
      n_checks++; if (d > 64 || d < -64) begin n_fail++; $display("FAIL midrst_after_mag got %0d want %0d +-64", $signed(mag_out), mag_diag); end
      take_output();
   endtask

   // Source and sink always ready: one result every ITER+2 cycles.
   task automatic test_back_to_back();
      int cyc, d;
      x_in = 32'h1000_0000; y_in = 32'h0; angle_in = 32'h1000_0000;
      in_valid = 1'b1;
      out_ready = 1'b1;
      wait_out(cyc);
      n_checks++; if (cyc != ITER + 1) begin n_fail++; $display("FAIL b2b_first got %0d edges want %0d", cyc, ITER + 1); end
      d = $signed(angle_out - 32'h1000_0000);
      n_checks++; if (d > 256 || d < -256) begin n_fail++; $display("FAIL b2b_angle1 got %h want 10000000 +-0x100", angle_out); end
      wait_out(cyc);
      n_checks++; if (cyc != ITER + 2) begin n_fail++; $display("FAIL b2b_period got %0d edges want %0d", cyc, ITER + 2); end
      d = int'($signed(mag_out)) - int'(MAG_UNIT);
      n_checks++; if (d > 64 || d < -64) begin n_fail++; $display("FAIL b2b_mag2 got %h want %h +-64", mag_out, MAG_UNIT); end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got r=%b v=%b want r=1 v=0", in_ready, out_valid); end
   endtask

   initial begin
      mag_diag = $rtoi(1.4142135623730951 * CORDIC_GAIN * 268435456.0 + 0.5);
      test_reset();
      test_axis_and_latency();
      test_diagonal();
      test_quadrant_offset();
      test_saturation();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
